uart_cmd_scheduler: RTL and testbench

- Shares one UART transmit line among NUM_REQ command requesters, e.g. the wake, voice-command and open/close key-flag sources.
- Today these drive separate transmitters through a priority mux on line_tx, so two flags that overlap corrupt or lose frames.
- This block latches every request as pending and grants the shared line by fixed priority.
- It serializes each 16-bit command frame as two 8N1 bytes, high byte first, then inserts an idle gap before the next frame.

---
 rtl/uart_cmd_pkg.sv | 37 +++
 rtl/uart_byte_tx.sv | 114 +++++++++++
 rtl/uart_cmd_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_uart_cmd_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_pkg
//  Description : Shared definitions for the UART command scheduler: FSM
//                state encodings, known command frames (command byte followed
//                by checksum = cmd + 0xB3) and baud/width helper functions.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_START = 3'd1;
    localparam state_t S_DATA  = 3'd2;
    localparam state_t S_STOP  = 3'd3;
    localparam state_t S_GAP   = 3'd4;

    localparam logic [15:0] CMD_CLOSE = 16'h01B4;
    localparam logic [15:0] CMD_OPEN  = 16'h02B5;
    localparam logic [15:0] CMD_LY    = 16'h03B6;
    localparam logic [15:0] CMD_BC    = 16'h04B7;
    localparam logic [15:0] CMD_NH    = 16'h05B8;

    // Clocks per bit, truncating integer division.
    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx
//  Description : 8N1 byte serializer. A byte is accepted when start and
//                ready are both high; the start bit appears on tx at the same
//                edge. ready is also high in the last clock of the stop bit,
//                so a following byte can be chained with no idle time.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                start, data   - load request and byte to send
//                ready         - a new byte is accepted this cycle
//                byte_end      - last clock of the stop bit
//                tx            - serial output, idles high
//  Revision    : 1.0  initial release
// ============================================================================
module uart_byte_tx
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       byte_end,
    output logic       tx
);

    localparam int            BW          = cnt_width(BAUD_DIV);
    localparam logic [BW-1:0] C_BAUD_LAST = BW'(BAUD_DIV - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          w_bit_end;

    assign w_bit_end = (baud_q == C_BAUD_LAST);
    assign byte_end  = (state_q == S_STOP) && w_bit_end;
    assign ready     = (state_q == S_IDLE) || byte_end;
    assign tx        = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;

        if (state_q != S_IDLE) begin
            baud_d = w_bit_end ? '0 : baud_q + 1'b1;
        end

        // The shift register is consumed LSB first: bit 0 leaves at the end
        // of the start bit and each data bit boundary exposes the next one.
        case (state_q)
            S_START: begin
                if (w_bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start && ready) begin
            state_d = S_START;
            baud_d  = '0;
            bit_d   = 3'd0;
            shreg_d = data;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_scheduler
//  Description : Shares one UART line among NUM_REQ requesters. Requests are
//                latched as pending, granted lowest-index first, and each
//                16-bit frame is sent as two 8N1 bytes (high byte first)
//                followed by GAP_BITS idle bit-times.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                req           - one-cycle request pulses, bit i = frame i
//                frame_tbl     - frame i at [16i+15:16i], sampled at grant
//                line_tx       - shared serial output, idles high
//                busy          - frame or its gap in progress
//                grant_id      - index of the current/last granted frame
//                done          - pulse at the end of a frame's gap
//                merged        - pulse when a request hits an already
//                                pending bit
//  Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_scheduler
    import uart_cmd_pkg::*;
#(
    parameter int NUM_REQ  = 5,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int GAP_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] frame_tbl,
    output logic                  line_tx,
    output logic                  busy,
    output logic [2:0]            grant_id,
    output logic                  done,
    output logic                  merged
);

    localparam int            BAUD_DIV    = calc_baud_div(CLK_FREQ, BAUD);
    localparam int            BW          = cnt_width(BAUD_DIV);
    localparam int            GW          = cnt_width(GAP_BITS);
    localparam logic [BW-1:0] C_BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [GW-1:0] C_GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    // Scheduler phases: S_DATA covers start/data/stop of both bytes, which
    // the serializer times on its own; only the gap is timed here.
    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [2:0]           grant_id_q, grant_id_d;
    logic [7:0]           lo_byte_q, lo_byte_d;
    logic                 byte_q, byte_d;
    logic [BW-1:0]        gap_baud_q, gap_baud_d;
    logic [GW-1:0]        gap_bit_q, gap_bit_d;
    logic                 done_q, done_d;
    logic                 merged_q, merged_d;

    logic [2:0]           w_win_idx;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [15:0]          w_win_frame;
    logic [NUM_REQ-1:0]   w_clr;
    logic                 w_grant;
    logic                 w_tx_start;
    logic [7:0]           w_tx_data;
    logic                 w_tx_ready;
    logic                 w_byte_end;

    // Lowest set index wins: scanning downward lets the last hit stick.
    always_comb begin
        w_win_idx   = 3'd0;
        w_win_oh    = '0;
        w_win_frame = 16'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                w_win_idx   = 3'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_win_frame = frame_tbl[16*i +: 16];
            end
        end
    end

    assign w_grant    = (state_q == S_IDLE) && (|pending_q) && w_tx_ready;
    assign w_clr      = w_grant ? w_win_oh : '0;
    // High byte goes straight from the table at grant; the low byte is
    // chained in on the last stop-bit clock of the first byte.
    assign w_tx_start = w_grant || ((state_q == S_DATA) && w_byte_end && !byte_q);
    assign w_tx_data  = w_grant ? w_win_frame[15:8] : lo_byte_q;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        lo_byte_d  = lo_byte_q;
        byte_d     = byte_q;
        gap_baud_d = gap_baud_q;
        gap_bit_d  = gap_bit_q;
        done_d     = 1'b0;
        // A request on the same edge that its bit is granted re-arms the bit
        // (frame sent again) rather than merging into the frame now leaving.
        pending_d  = (pending_q & ~w_clr) | req;
        merged_d   = |(req & pending_q & ~w_clr);

        case (state_q)
            S_IDLE: begin
                if (w_grant) begin
                    state_d    = S_DATA;
                    grant_id_d = w_win_idx;
                    lo_byte_d  = w_win_frame[7:0];
                    byte_d     = 1'b0;
                end
            end
            S_DATA: begin
                if (w_byte_end) begin
                    if (!byte_q) begin
                        byte_d = 1'b1;
                    end else if (GAP_BITS == 0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_GAP;
                        gap_baud_d = '0;
                        gap_bit_d  = '0;
                    end
                end
            end
            S_GAP: begin
                if (gap_baud_q == C_BAUD_LAST) begin
                    gap_baud_d = '0;
                    if (gap_bit_q == C_GAP_LAST) begin
                        state_d   = S_IDLE;
                        gap_bit_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        gap_bit_d = gap_bit_q + 1'b1;
                    end
                end else begin
                    gap_baud_d = gap_baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            grant_id_q <= 3'd0;
            lo_byte_q  <= 8'd0;
            byte_q     <= 1'b0;
            gap_baud_q <= '0;
            gap_bit_q  <= '0;
            done_q     <= 1'b0;
            merged_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            grant_id_q <= grant_id_d;
            lo_byte_q  <= lo_byte_d;
            byte_q     <= byte_d;
            gap_baud_q <= gap_baud_d;
            gap_bit_q  <= gap_bit_d;
            done_q     <= done_d;
            merged_q   <= merged_d;
        end
    end

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (w_tx_start),
        .data     (w_tx_data),
        .ready    (w_tx_ready),
        .byte_end (w_byte_end),
        .tx       (line_tx)
    );

    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_id_q;
    assign done     = done_q;
    assign merged   = merged_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_scheduler
//  Description : Self-checking bench for uart_cmd_scheduler. A line decoder
//                rebuilds frames from line_tx and checks them against a
//                queue of expected frames pushed when requests are driven.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_scheduler;

    localparam int NR         = 5;
    localparam int DIV        = 16;
    localparam int GB         = 2;
    localparam int FRAME_CLKS = (20 + GB) * DIV;

    typedef struct {
        logic [2:0]  id;
        logic [15:0] frm;
    } exp_t;

    typedef struct {
        logic [NR-1:0] req;
        int            n;
        int            ids[5];
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [16*NR-1:0]  frame_tbl;
    logic              line_tx, busy, done, merged;
    logic [2:0]        grant_id;

    logic [15:0]       frm [NR];
    exp_t              exp_q[$];
    int                falls_q[$];
    int                dones_q[$];

    int cyc = 0;
    int last_rst_cyc = -1;
    int done_total = 0;
    int merged_total = 0;
    int busy_cnt = 0;
    int low_cnt = 0;
    int frames_rx = 0;
    int n_assert = 0;
    int n_fail = 0;

    uart_cmd_scheduler #(
        .NUM_REQ  (NR),
        .CLK_FREQ (16),
        .BAUD     (1),
        .GAP_BITS (GB)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .frame_tbl (frame_tbl),
        .line_tx   (line_tx),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done),
        .merged    (merged)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) last_rst_cyc = cyc;
        if (done) begin
            done_total++;
            dones_q.push_back(cyc);
        end
        if (merged) merged_total++;
        if (busy) busy_cnt++;
        if (!line_tx) low_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_assert++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, expv, expv);
        end
    endtask

    // Receives one 8N1 byte: waits for the start edge, samples mid-bit.
    task automatic rx_byte(output logic [7:0] b, output logic stop_ok,
                           output int fcyc, output logic [2:0] gid);
        @(negedge line_tx);
        @(negedge clk);
        fcyc = cyc;
        repeat (7) @(negedge clk);
        gid = grant_id;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = line_tx;
        end
        repeat (DIV) @(negedge clk);
        stop_ok = line_tx;
    endtask

    initial begin : frame_mon
        logic [7:0] b0, b1;
        logic       s0, s1;
        int         f0, f1;
        logic [2:0] g0, g1;
        exp_t       e;
        forever begin
            rx_byte(b0, s0, f0, g0);
            rx_byte(b1, s1, f1, g1);
            falls_q.push_back(f0);
            // Frames cut by reset are not real frames.
            if (last_rst_cyc < f0) begin
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got 0x%02h%02h required none", b0, b1);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_bytes", {b0, b1}, e.frm);
                    chk("frame_grant_id", g0, e.id);
                    chk("stop_bits", {s0, s1}, 2'b11);
                    chk("byte1_start_offset", f1 - f0, 10 * DIV);
                end
                frames_rx++;
            end
        end
    end

    task automatic wait_dones(input int target, input int budget);
        int k = 0;
        while (done_total < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_total < target) begin
            n_assert++;
            n_fail++;
            $display("FAIL wait_done: done count %0d required %0d", done_total, target);
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id  = 3'(id);
        e.frm = frm[id];
        exp_q.push_back(e);
    endtask

    task automatic pulse_req(input logic [NR-1:0] r);
        @(negedge clk);
        req = r;
        @(negedge clk);
        req = '0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[5];
        int   base_done, base_rx, base_merged, base_busy, base_low, req_cyc;

        frm[0] = 16'h01B4;
        frm[1] = 16'h02B5;
        frm[2] = 16'h03B6;
        frm[3] = 16'h04B7;
        frm[4] = 16'h05B8;
        frame_tbl = {frm[4], frm[3], frm[2], frm[1], frm[0]};

        vecs[0] = '{5'b00001, 1, '{0, 0, 0, 0, 0}};
        vecs[1] = '{5'b01000, 1, '{3, 0, 0, 0, 0}};
        vecs[2] = '{5'b10010, 2, '{1, 4, 0, 0, 0}};
        vecs[3] = '{5'b00101, 2, '{0, 2, 0, 0, 0}};
        vecs[4] = '{5'b11111, 5, '{0, 1, 2, 3, 4}};

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_line_tx", line_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_done", done, 0);
        chk("rst_merged", merged, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven request patterns
        for (int v = 0; v < 5; v++) begin
            repeat (3) @(negedge clk);
            falls_q.delete();
            dones_q.delete();
            base_done   = done_total;
            base_rx     = frames_rx;
            base_merged = merged_total;
            base_busy   = busy_cnt;
            for (int j = 0; j < vecs[v].n; j++) push_exp(vecs[v].ids[j]);
            @(negedge clk);
            req     = vecs[v].req;
            req_cyc = cyc;
            @(negedge clk);
            req = '0;
            wait_dones(base_done + vecs[v].n, vecs[v].n * (FRAME_CLKS + 4) + 20);
            repeat (2) @(negedge clk);
            chk("vec_done_count", done_total - base_done, vecs[v].n);
            chk("vec_frames_rx", frames_rx - base_rx, vecs[v].n);
            chk("vec_exp_left", exp_q.size(), 0);
            chk("vec_merged", merged_total - base_merged, 0);
            chk("vec_busy_cycles", busy_cnt - base_busy, FRAME_CLKS * vecs[v].n);
            chk("vec_idle_busy", busy, 0);
            chk("vec_grant_hold", grant_id, vecs[v].ids[vecs[v].n - 1]);
            if (falls_q.size() >= vecs[v].n && dones_q.size() >= vecs[v].n) begin
                chk("vec_latency", falls_q[0] - req_cyc, 2);
                for (int j = 0; j < vecs[v].n; j++) begin
                    chk("vec_frame_len", dones_q[j] - falls_q[j], FRAME_CLKS);
                    if (j > 0) chk("vec_idle_between", falls_q[j] - dones_q[j-1], 1);
                end
            end else begin
                n_assert++;
                n_fail++;
                $display("FAIL vec_timing: got %0d falls %0d dones required %0d", falls_q.size(), dones_q.size(), vecs[v].n);
            end
        end

        // Duplicate request while pending: merged once, one extra frame
        repeat (3) @(negedge clk);
        base_done   = done_total;
        base_rx     = frames_rx;
        base_merged = merged_total;
        push_exp(0);
        push_exp(2);
        pulse_req(5'b00001);
        repeat (40) @(negedge clk);
        pulse_req(5'b00100);
        repeat (40) @(negedge clk);
        pulse_req(5'b00100);
        wait_dones(base_done + 2, 2 * (FRAME_CLKS + 4) + 20);
        repeat (2) @(negedge clk);
        chk("merge_pulses", merged_total - base_merged, 1);
        chk("merge_frames", frames_rx - base_rx, 2);
        chk("merge_done_count", done_total - base_done, 2);
        chk("merge_exp_left", exp_q.size(), 0);

        // Request on the grant edge of the same requester: sent twice
        repeat (3) @(negedge clk);
        falls_q.delete();
        dones_q.delete();
        base_done   = done_total;
        base_rx     = frames_rx;
        base_merged = merged_total;
        push_exp(0);
        push_exp(0);
        @(negedge clk);
        req = 5'b00001;
        @(negedge clk);
        req = 5'b00001;
        @(negedge clk);
        req = '0;
        wait_dones(base_done + 2, 2 * (FRAME_CLKS + 4) + 20);
        repeat (2) @(negedge clk);
        chk("regrant_frames", frames_rx - base_rx, 2);
        chk("regrant_merged", merged_total - base_merged, 0);
        chk("regrant_exp_left", exp_q.size(), 0);
        if (falls_q.size() >= 2 && dones_q.size() >= 1)
            chk("regrant_idle_between", falls_q[1] - dones_q[0], 1);
        else begin
            n_assert++;
            n_fail++;
            $display("FAIL regrant_timing: got %0d falls required 2", falls_q.size());
        end

        // Table change mid-frame must not affect the frame in flight
        repeat (3) @(negedge clk);
        base_done = done_total;
        base_rx   = frames_rx;
        push_exp(3);
        pulse_req(5'b01000);
        repeat (60) @(negedge clk);
        frame_tbl[63:48] = 16'hA55A;
        repeat (150) @(negedge clk);
        frame_tbl[63:48] = 16'h5AA5;
        wait_dones(base_done + 1, FRAME_CLKS + 24);
        repeat (2) @(negedge clk);
        frame_tbl[63:48] = frm[3];
        chk("tblchg_frames", frames_rx - base_rx, 1);
        chk("tblchg_exp_left", exp_q.size(), 0);

        // Reset during the data bits of the second byte
        repeat (3) @(negedge clk);
        pulse_req(5'b00010);
        repeat (195) @(negedge clk);
        pulse_req(5'b10000);
        repeat (3) @(negedge clk);
        chk("prerst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_line_tx", line_tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_pending", u_dut.pending_q, 0);
        rst = 1'b0;
        base_done = done_total;
        base_busy = busy_cnt;
        base_low  = low_cnt;
        repeat (800) @(negedge clk);
        chk("postrst_done", done_total - base_done, 0);
        chk("postrst_busy", busy_cnt - base_busy, 0);
        chk("postrst_line_low", low_cnt - base_low, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
